robo_motion_scheduler: RTL and testbench

ROBO_MOTION_SCHEDULER -- requirements
Module: robo_motion_scheduler

---
 rtl/robo_pkg.sv | 14 +
 rtl/robo_step_prescaler.sv | 26 ++
 rtl/robo_motion_scheduler.sv | 113 +++++++++++
 tb/tb_robo_motion_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared types for the motion scheduler: FSM state encoding and command-type constants.
package robo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_TURN    = 2'd2,
    ST_SETTLE  = 2'd3
  } robo_state_e;

  localparam logic CMD_ADVANCE = 1'b0;
  localparam logic CMD_ROTATE  = 1'b1;

endpackage

// File: rtl/robo_step_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled, tick marks the last count.
module robo_step_prescaler #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [7:0] cnt_q;

  assign tick = (cnt_q == 8'(DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (clear) begin
      cnt_q <= 8'd0;
    end else if (enable) begin
      cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/robo_motion_scheduler.sv
// Motion scheduler: turns advance/rotate commands into timed step pulses with a
// settle window, aborting an advance when the front sensor trips.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a command, motors off
// ST_ADVANCE | forward drive on, stepping; head aborts to ST_SETTLE
// ST_TURN    | rotate drive on, stepping; head ignored
// ST_SETTLE  | motors off for SETTLE_CYC cycles, done in the last one
module robo_motion_scheduler
  import robo_pkg::*;
#(
  parameter int FWD_STEPS  = 4,
  parameter int TURN_STEPS = 8,
  parameter int DIV        = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_turn,
  output logic       cmd_ready,
  input  logic       head,
  output logic       motor_fwd,
  output logic       motor_rot,
  output logic       step_pulse,
  output logic       done,
  output logic       abort,
  output logic [7:0] step_count
);

  robo_state_e state_q, state_d;
  logic [7:0]  remaining_q;
  logic [7:0]  settle_q;
  logic        tick;
  logic        accept;

  assign accept = cmd_valid && cmd_ready;

  robo_step_prescaler #(.DIV(DIV)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (motor_fwd || motor_rot),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    motor_fwd  = 1'b0;
    motor_rot  = 1'b0;
    step_pulse = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_turn == CMD_ROTATE) ? ST_TURN : ST_ADVANCE;
      end
      ST_ADVANCE: begin
        motor_fwd = 1'b1;
        // The obstacle wins over a coincident step.
        if (head) begin
          abort   = 1'b1;
          state_d = ST_SETTLE;
        end else if (tick) begin
          step_pulse = 1'b1;
          if (remaining_q == 8'd1) state_d = ST_SETTLE;
        end
      end
      ST_TURN: begin
        motor_rot = 1'b1;
        if (tick) begin
          step_pulse = 1'b1;
          if (remaining_q == 8'd1) state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 8'd0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      settle_q    <= 8'd0;
      step_count  <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        remaining_q <= (cmd_turn == CMD_ROTATE) ? 8'(TURN_STEPS) : 8'(FWD_STEPS);
        step_count  <= 8'd0;
      end else if (step_pulse) begin
        remaining_q <= remaining_q - 8'd1;
        if (step_count != 8'hFF) step_count <= step_count + 8'd1;
      end
      // Settle timer loads on entry and counts down to its terminal zero.
      if (state_q != ST_SETTLE && state_d == ST_SETTLE) begin
        settle_q <= 8'(SETTLE_CYC - 1);
      end else if (state_q == ST_SETTLE && settle_q != 8'd0) begin
        settle_q <= settle_q - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_robo_motion_scheduler.sv
// Directed bench for robo_motion_scheduler: default instance plus a DIV=1, FWD_STEPS=1 instance.
module tb_robo_motion_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_turn;
  logic       head;
  logic       cmd_ready, motor_fwd, motor_rot, step_pulse, done, abort;
  logic [7:0] step_count;
  logic       f_ready, f_fwd, f_rot, f_pulse, f_done, f_abort;
  logic [7:0] f_count;
  logic [5:0] exp_v;
  int         tests = 0;
  int         fails = 0;

  always #5 clock = ~clock;

  wire [5:0] obs   = {cmd_ready, motor_fwd, motor_rot, step_pulse, done, abort};
  wire [5:0] obs_f = {f_ready, f_fwd, f_rot, f_pulse, f_done, f_abort};

  robo_motion_scheduler u_dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_turn(cmd_turn),
    .cmd_ready(cmd_ready), .head(head), .motor_fwd(motor_fwd), .motor_rot(motor_rot),
    .step_pulse(step_pulse), .done(done), .abort(abort), .step_count(step_count)
  );

  robo_motion_scheduler #(.FWD_STEPS(1), .DIV(1)) u_fast (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_turn(cmd_turn),
    .cmd_ready(f_ready), .head(head), .motor_fwd(f_fwd), .motor_rot(f_rot),
    .step_pulse(f_pulse), .done(f_done), .abort(f_abort), .step_count(f_count)
  );

  // Leaves the bench at the falling edge of cycle 0 (the first cycle after release).
  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_turn = 1'b0; head = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_turn = 1'b0; head = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    tests++;
    if (obs !== 6'b100000 || step_count !== 8'd0) begin
      fails++; $display("FAIL reset_hold outputs=%b count=%0d required=100000/0", obs, step_count);
    end
    reset = 1'b0; cmd_valid = 1'b0; head = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release cmd_ready=%b required=1", cmd_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_advance();
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      cmd_valid = (c == 10); cmd_turn = 1'b0;
      #1;
      exp_v = {(c <= 10 || c >= 21), (c >= 11 && c <= 18), 1'b0,
               (c >= 12 && c <= 18 && c % 2 == 0), (c == 20), 1'b0};
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL advance cycle=%0d outputs=%b required=%b", c, obs, exp_v);
      end
      @(negedge clock);
    end
    tests++;
    if (step_count !== 8'd4) begin
      fails++; $display("FAIL advance_count step_count=%0d required=4", step_count);
    end
  endtask

  task automatic test_rotate();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      cmd_valid = (c == 10); cmd_turn = (c == 10); head = (c == 15);
      #1;
      exp_v = {(c <= 10 || c >= 29), 1'b0, (c >= 11 && c <= 26),
               (c >= 12 && c <= 26 && c % 2 == 0), (c == 28), 1'b0};
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL rotate cycle=%0d outputs=%b required=%b", c, obs, exp_v);
      end
      @(negedge clock);
    end
    tests++;
    if (step_count !== 8'd8) begin
      fails++; $display("FAIL rotate_count step_count=%0d required=8", step_count);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      cmd_valid = (c == 10); cmd_turn = 1'b0; head = (c == 14);
      #1;
      exp_v = {(c <= 10 || c >= 17), (c >= 11 && c <= 14), 1'b0,
               (c == 12), (c == 16), (c == 14)};
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL abort cycle=%0d outputs=%b required=%b", c, obs, exp_v);
      end
      @(negedge clock);
    end
    tests++;
    if (step_count !== 8'd1) begin
      fails++; $display("FAIL abort_count step_count=%0d required=1", step_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      cmd_valid = (c >= 10); cmd_turn = 1'b0;
      #1;
      exp_v = {(c <= 10 || c == 21), ((c >= 11 && c <= 18) || (c >= 22 && c <= 29)), 1'b0,
               ((c >= 12 && c <= 18 && c % 2 == 0) || (c >= 23 && c <= 29 && c % 2 == 1)),
               (c == 20), 1'b0};
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL back_to_back cycle=%0d outputs=%b required=%b", c, obs, exp_v);
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      cmd_valid = (c == 10); cmd_turn = 1'b0;
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    #1;
    tests++;
    if (motor_fwd !== 1'b1) begin
      fails++; $display("FAIL mid_before motor_fwd=%b required=1", motor_fwd);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (motor_fwd !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL mid_async motor_fwd=%b cmd_ready=%b required=0/1", motor_fwd, cmd_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      tests++;
      if (done !== 1'b0 || abort !== 1'b0) begin
        fails++; $display("FAIL mid_hold done=%b abort=%b required=0/0", done, abort);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (obs !== 6'b100000) begin
        fails++; $display("FAIL mid_release cycle=%0d outputs=%b required=100000", c, obs);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_div1();
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      cmd_valid = (c == 10); cmd_turn = 1'b0;
      #1;
      exp_v = {(c <= 10 || c >= 14), (c == 11), 1'b0, (c == 11), (c == 13), 1'b0};
      tests++;
      if (obs_f !== exp_v) begin
        fails++; $display("FAIL div1 cycle=%0d outputs=%b required=%b", c, obs_f, exp_v);
      end
      @(negedge clock);
    end
    tests++;
    if (f_count !== 8'd1) begin
      fails++; $display("FAIL div1_count step_count=%0d required=1", f_count);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_rotate();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
